popcount_seq_ctrl: RTL and testbench
====================================

POPCOUNT_SEQ_CTRL -- requirements
Module: popcount_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 16, the maximum beats per job (1..31).
REQ-002 SHALL have parameter ACC_W, default 8, the accumulator width; it SHALL satisfy 2^ACC_W > 11*MAX_BEATS.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, job request, sampled only in IDLE.
REQ-006 SHALL have port num_beats, input, 5, beats in the job, sampled with start.
REQ-007 SHALL have port mask, input, 11, lane enable, sampled with start and held for the job.
REQ-008 SHALL have port abort, input, 1, synchronous job cancel.
REQ-009 SHALL have port in_valid, input, 1, beat valid.
REQ-010 SHALL have port in_ready, output, 1, beat accept.
REQ-011 SHALL have port in_data, input, 11, beat bits to count.
REQ-012 SHALL have port out_valid, output, 1, result valid.
REQ-013 SHALL have port out_ready, input, 1, result accept.
REQ-014 SHALL have port out_count, output, ACC_W, job popcount total.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 SHALL have port err, output, 1, one-cycle pulse on a rejected start.

Function
REQ-017 SHALL instantiate one 11-to-4 compressor (adder_11to4) fed with in_data AND the latched mask, producing a 4-bit count of 0..11 per beat.
REQ-018 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-019 IDLE: start with 1 <= num_beats <= MAX_BEATS SHALL latch num_beats and mask, clear the accumulator and beat counter, and move to ACCUM next cycle.
REQ-020 IDLE: start with num_beats = 0 or num_beats > MAX_BEATS SHALL pulse err for exactly one cycle and remain in IDLE.
REQ-021 in_ready SHALL equal 1 only in ACCUM; a beat is accepted in a cycle where in_valid and in_ready are both 1.
REQ-022 On each accepted beat, acc SHALL take acc + zero-extended compressor output, and the beat counter SHALL increment.
REQ-023 In a cycle with in_valid = 0, acc and the beat counter SHALL hold; gaps of any length are legal.
REQ-024 On the accepted beat where counter+1 equals the latched num_beats, out_count SHALL register the final sum and the FSM SHALL move to DONE.
REQ-025 out_valid SHALL go high the cycle after the last beat, giving one-cycle latency.
REQ-026 DONE: out_valid = 1 and out_count SHALL stay stable until out_ready = 1.
REQ-027 out_valid with out_ready in the same cycle SHALL return the FSM to IDLE next cycle and drop out_valid.
REQ-028 A start asserted during DONE or ACCUM SHALL be ignored, with no err and no latch.
REQ-029 abort = 1 in ACCUM or DONE SHALL return the FSM to IDLE next cycle, clear acc and the counter, deassert out_valid, and produce no err.
REQ-030 Simultaneous abort and start in IDLE: abort SHALL win, so no job starts and no err pulses.
REQ-031 Simultaneous abort and out_ready in DONE SHALL return to IDLE; the handshake counts as discarded.
REQ-032 The accumulator SHALL never wrap under the REQ-002 constraint; no saturation logic is required.
REQ-033 The outputs in_ready, out_valid, busy and err SHALL be registered or purely state-decoded, with no combinational path from in_valid or out_ready.

Reset
REQ-034 reset = 1 SHALL asynchronously force IDLE and set in_ready = 0, out_valid = 0, out_count = 0, busy = 0 and err = 0, and SHALL clear acc, the counter, the latched num_beats and the latched mask.
REQ-035 Reset asserted mid-job SHALL discard the job; after release the block SHALL accept a new start on the first clock edge.

Verification
REQ-036 Test: start, num_beats = 3, mask = 0x7FF; beats 0x7FF, 0x000, 0x555 back-to-back. Required response: out_valid one cycle after the 3rd beat, out_count = 17.
REQ-037 Test: start, num_beats = 2, mask = 0x00F; beats 0x7FF and 0x0F0 with 4 idle cycles between them. Required response: out_count = 4, in_ready high throughout ACCUM.
REQ-038 Test: start with num_beats = 0, then start with num_beats = 17. Required response: err pulses one cycle each, busy stays 0, no out_valid.
REQ-039 Test: job of 16 beats of 0x7FF, out_ready held 0 for 5 cycles. Required response: out_count = 176 held stable with out_valid = 1, IDLE the cycle after out_ready rises.
REQ-040 Test: abort after the 2nd of 4 beats, then a new 1-beat job with 0x001. Required response: out_count = 1, no residue from the aborted job.
REQ-041 Test: reset pulsed during ACCUM and during DONE. Required response: all outputs 0 immediately, without waiting for a clock edge; the next job computes correctly.

Source files
------------

// File: rtl/popcount_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : popcount_seq_ctrl (with helper adder_11to4)
// Description : Sequenced popcount of masked 11-bit beats over a job of
//               1..MAX_BEATS beats, result held until accepted.
// Revision    : 1.0 - initial release
// ============================================================================

module adder_11to4 (
    input  logic [10:0] bits,
    output logic [3:0]  count
);
    always_comb begin
        count = 4'd0;
        for (int i = 0; i < 11; i++) begin
            count = count + {3'd0, bits[i]};
        end
    end
endmodule

module popcount_seq_ctrl #(
    parameter int MAX_BEATS = 16,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       num_beats,
    input  logic [10:0]      mask,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             busy,
    output logic             err
);
    localparam logic [4:0] c_max_beats = 5'(MAX_BEATS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [4:0]        r_num_beats;
    logic [10:0]       r_mask;
    logic [ACC_W-1:0]  r_acc;
    logic [4:0]        r_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [ACC_W-1:0]  r_out_count;
    logic              r_busy;
    logic              r_err;

    logic [3:0]        w_beat_count;
    logic [ACC_W-1:0]  w_acc_next;
    logic              w_beat_fire;
    logic              w_start_ok;

    adder_11to4 u_adder (
        .bits  (in_data & r_mask),
        .count (w_beat_count)
    );

    assign w_acc_next  = r_acc + ACC_W'(w_beat_count);
    assign w_beat_fire = r_in_ready & in_valid;
    assign w_start_ok  = (num_beats != 5'd0) && (num_beats <= c_max_beats);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign busy      = r_busy;
    assign err       = r_err;

    // Handshake outputs are registered alongside the state so none of them
    // depends combinationally on in_valid or out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_num_beats <= 5'd0;
            r_mask      <= 11'd0;
            r_acc       <= '0;
            r_cnt       <= 5'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_count <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!abort && start) begin
                        if (w_start_ok) begin
                            r_num_beats <= num_beats;
                            r_mask      <= mask;
                            r_acc       <= '0;
                            r_cnt       <= 5'd0;
                            r_in_ready  <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_ACCUM;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (abort) begin
                        r_acc      <= '0;
                        r_cnt      <= 5'd0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (w_beat_fire) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 5'd1;
                        if ((r_cnt + 5'd1) == r_num_beats) begin
                            r_out_count <= w_acc_next;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // An abort coinciding with out_ready discards the result.
                    if (abort || out_ready) begin
                        r_acc       <= '0;
                        r_cnt       <= 5'd0;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_popcount_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount_seq_ctrl
// Description : Scoreboard bench for popcount_seq_ctrl with a $countones model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_popcount_seq_ctrl;
    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  num_beats;
    logic [10:0] mask;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_count;
    logic        busy;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sb_q[$];
    logic [10:0] tb_beats[$];
    int          tb_gaps[$];

    popcount_seq_ctrl #(.MAX_BEATS(16), .ACC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_beats (num_beats),
        .mask      (mask),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on each newly presented result, then checks it stays stable.
    initial begin : monitor
        bit prev_valid = 1'b0;
        int cur_exp    = 0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    cur_exp = sb_q.pop_front();
                    check("out_count", 32'(out_count), cur_exp);
                end
            end else if (out_valid && prev_valid) begin
                check("out_count_stable", 32'(out_count), cur_exp);
            end
            prev_valid = out_valid;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_count"}, 32'(out_count), 0);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_err"},       32'(err),       0);
    endtask

    task automatic start_job(input logic [4:0] nb, input logic [10:0] mk);
        start = 1'b1; num_beats = nb; mask = mk;
        @(posedge clk); #1;
        start = 1'b0;
        mask  = 11'($urandom);   // must not affect the running job
        num_beats = 5'($urandom);
    endtask

    task automatic send_beat(input logic [10:0] d, input int gap);
        bit ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            check("in_ready_in_gap", 32'(in_ready), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("beat_accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 11'($urandom);
    endtask

    task automatic run_job(input logic [4:0] nb, input logic [10:0] mk, input int hold);
        int exp = 0;
        foreach (tb_beats[i]) exp += $countones(tb_beats[i] & mk);
        sb_q.push_back(exp);
        start_job(nb, mk);
        foreach (tb_beats[i]) send_beat(tb_beats[i], tb_gaps[i]);
        @(negedge clk);
        check("out_valid_latency", 32'(out_valid), 1);
        check("busy_in_done",      32'(busy),      1);
        check("in_ready_in_done",  32'(in_ready),  0);
        repeat (hold) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 0);
        check("busy_after_ack", 32'(busy),      0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_beats = 5'd0; mask = 11'd0;
        abort = 1'b0; in_valid = 1'b0; in_data = 11'd0; out_ready = 1'b0;
        #2;
        check_all_zero("reset_init");
        @(posedge clk); #1;
        reset = 1'b0;

        // Three back-to-back beats, full mask: 11 + 0 + 6.
        tb_beats = '{11'h7FF, 11'h000, 11'h555}; tb_gaps = '{0, 0, 0};
        run_job(5'd3, 11'h7FF, 0);

        // Masked job with a 4-cycle gap: 4 + 0.
        tb_beats = '{11'h7FF, 11'h0F0}; tb_gaps = '{0, 4};
        run_job(5'd2, 11'h00F, 0);

        // Rejected starts.
        start = 1'b1; num_beats = 5'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_nb0",  32'(err),  1);
        check("busy_nb0", 32'(busy), 0);
        @(posedge clk); #1;
        check("err_pulse_end", 32'(err), 0);
        start = 1'b1; num_beats = 5'd17;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_nb17",       32'(err),       1);
        check("busy_nb17",      32'(busy),      0);
        check("out_valid_nb17", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("err_pulse_end17", 32'(err), 0);

        // Abort beats start in IDLE.
        start = 1'b1; abort = 1'b1; num_beats = 5'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", 32'(busy), 0);
        check("abort_start_err",  32'(err),  0);

        // Maximum job, result held back for 5 cycles: 16 * 11 = 176.
        tb_beats = {}; tb_gaps = {};
        for (int i = 0; i < 16; i++) begin tb_beats.push_back(11'h7FF); tb_gaps.push_back(0); end
        run_job(5'd16, 11'h7FF, 5);

        // Abort after 2 of 4 beats, with an ignored start during ACCUM.
        start_job(5'd4, 11'h7FF);
        start = 1'b1; num_beats = 5'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_accum_err",  32'(err),  0);
        check("start_in_accum_busy", 32'(busy), 1);
        send_beat(11'h7FF, 0);
        send_beat(11'h7FF, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy",     32'(busy),     0);
        check("abort_in_ready", 32'(in_ready), 0);
        check("abort_err",      32'(err),      0);
        tb_beats = '{11'h001}; tb_gaps = '{0};
        run_job(5'd1, 11'h7FF, 0);

        // Abort together with out_ready in DONE.
        sb_q.push_back(4);
        start_job(5'd1, 11'h7FF);
        send_beat(11'h0F0, 0);
        @(negedge clk);
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; out_ready = 1'b0;
        check("abort_done_valid", 32'(out_valid), 0);
        check("abort_done_busy",  32'(busy),      0);

        // Asynchronous reset during ACCUM.
        start_job(5'd3, 11'h7FF);
        send_beat(11'h7FF, 0);
        #2 reset = 1'b1;
        #1 check_all_zero("reset_accum");
        #1 reset = 1'b0;

        // Asynchronous reset during DONE.
        sb_q.push_back(10);
        @(posedge clk); #1;
        start_job(5'd1, 11'h7FF);
        send_beat(11'h3FF, 0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_all_zero("reset_done");
        #1 reset = 1'b0;
        @(posedge clk); #1;

        tb_beats = '{11'h00F, 11'h700}; tb_gaps = '{1, 0};
        run_job(5'd2, 11'h7FF, 1);

        // Randomized jobs.
        for (int j = 0; j < 12; j++) begin
            int nb = $urandom_range(1, 16);
            logic [10:0] mk = 11'($urandom);
            tb_beats = {}; tb_gaps = {};
            for (int i = 0; i < nb; i++) begin
                tb_beats.push_back(11'($urandom));
                tb_gaps.push_back($urandom_range(0, 2));
            end
            run_job(5'(nb), mk, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
